// File: rtl/toy_bus_dec_ord_ctrl.sv
// In-order ack controller for the toy bus LSU 1-to-2 request decoder.
// Tracks each accepted request's target and grants acks only at the FIFO head.
module toy_bus_dec_ord_ctrl #(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] SPLIT_ADDR = 32'h8000_0000,
   parameter int          CW         = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_req_vld,
   output logic          in_req_rdy,
   input  logic [31:0]   in_req_addr,
   output logic [1:0]    out_req_vld,
   input  logic [1:0]    out_req_rdy,
   output logic          req_sel,
   input  logic [1:0]    out_ack_vld,
   output logic [1:0]    out_ack_rdy,
   output logic          in_ack_vld,
   input  logic          in_ack_rdy,
   output logic          ack_sel,
   output logic [CW-1:0] outstanding,
   output logic          unexp_ack
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [DEPTH-1:0] fifo;
   logic             full;
   logic             empty;
   logic             head;
   logic             push;
   logic             pop;
   logic             stray;

   assign full  = (outstanding == CW'(DEPTH));
   assign empty = (outstanding == '0);
   assign head  = fifo[rptr];

   assign req_sel = (in_req_addr >= SPLIT_ADDR);
   assign ack_sel = head;

   always_comb begin
      out_req_vld          = 2'b00;
      out_req_vld[req_sel] = in_req_vld & !full;
      in_req_rdy           = !full & out_req_rdy[req_sel];
   end

   // Only the head port may ack; the other port is stalled, never dropped.
   always_comb begin
      out_ack_rdy       = 2'b00;
      out_ack_rdy[head] = !empty & in_ack_rdy;
      in_ack_vld        = !empty & out_ack_vld[head];
   end

   assign push  = in_req_vld & in_req_rdy;
   assign pop   = in_ack_vld & in_ack_rdy;
   assign stray = (out_ack_vld[0] & (empty | head))
                | (out_ack_vld[1] & (empty | !head));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         fifo        <= '0;
         outstanding <= '0;
         unexp_ack   <= 1'b0;
      end else begin
         if (push) begin
            fifo[wptr] <= req_sel;
            wptr       <= wptr + AW'(1);
         end
         if (pop)
            rptr <= rptr + AW'(1);
         if (push && !pop)
            outstanding <= outstanding + CW'(1);
         else if (pop && !push)
            outstanding <= outstanding - CW'(1);
         if (stray)
            unexp_ack <= 1'b1;
      end
   end

endmodule
